// File: rtl/mem_access_pkg.sv
// Shared MEM-stage encodings: control and write-back field positions, access
// sizes, FSM states, and the alignment / byte-lane helpers.
package mem_access_pkg;

  localparam int MC_RE      = 4;
  localparam int MC_WE      = 3;
  localparam int MC_UNS     = 2;
  localparam int MC_SIZE_LO = 0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Write-back control layout: {reg_dest, reg_we, data_sel[1:0]}
  localparam int WB_DEST_LO = 3;
  localparam int WB_REG_WE  = 2;
  localparam int WB_SEL_LO  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: lane_be = 4'b0001 << addr_lo;
      SIZE_HALF: lane_be = 4'b0011 << addr_lo;
      default:   lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extender.sv
// Picks the addressed byte/half out of a little-endian read word and
// sign- or zero-extends it; words pass through untouched.
module load_extender
  import mem_access_pkg::*;
#(
  parameter int NB_REG = 32
) (
  input  logic [NB_REG-1:0] i_rdata,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [NB_REG-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SIZE_BYTE: o_result = {{(NB_REG-8){~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_result = {{(NB_REG-16){~i_unsigned & w_half[15]}}, w_half};
      SIZE_WORD: o_result = i_rdata;
      default:   o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory request at a time, stalls the
// upstream stage until ack, and loads the MEM/WB register.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_WB       = 8,
  parameter int NB_MEM_CTRL = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_REG-1:0]      i_alu_result,
  input  logic [NB_REG-1:0]      i_store_data,
  input  logic [NB_MEM_CTRL-1:0] i_mem_ctrl,
  input  logic [NB_WB-1:0]       i_wb,
  input  logic [NB_REG-1:0]      i_pc,
  output logic                   o_stall,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [NB_REG-1:0]      o_dmem_addr,
  output logic [NB_REG-1:0]      o_dmem_wdata,
  output logic [3:0]             o_dmem_be,
  input  logic [NB_REG-1:0]      i_dmem_rdata,
  input  logic                   i_dmem_ack,
  output logic [NB_REG-1:0]      o_reg_wb,
  output logic [NB_REG-1:0]      o_ext_mem_o,
  output logic [NB_WB-1:0]       o_wb,
  output logic [NB_REG-1:0]      o_pc,
  output logic                   o_misaligned
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_dmem_req, r_dmem_we, r_misaligned, r_uns;
  logic [NB_REG-1:0]   r_dmem_addr, r_dmem_wdata, r_addr, r_pc_lat;
  logic [3:0]          r_dmem_be;
  logic [1:0]          r_size;
  logic [NB_WB-1:0]    r_wb_lat, r_wb;
  logic [NB_REG-1:0]   r_reg_wb, r_ext_mem, r_pc;

  logic [1:0]          w_size;
  logic                w_mem_op, w_is_store, w_misaligned;
  logic                w_alu_pass, w_reject, w_accept, w_complete;
  logic [NB_REG-1:0]   w_wdata, w_load_ext;
  logic [NB_WB-1:0]    w_wb_noreg;

  assign w_size       = i_mem_ctrl[MC_SIZE_LO +: 2];
  assign w_is_store   = i_mem_ctrl[MC_WE];  // re+we together is a store
  assign w_mem_op     = i_mem_ctrl[MC_RE] | i_mem_ctrl[MC_WE];
  assign w_misaligned = is_misaligned(w_size, i_alu_result[1:0]);
  assign w_wb_noreg   = {i_wb[WB_DEST_LO +: NB_REG_ADDR], 1'b0, i_wb[WB_SEL_LO +: WB_REG_WE]};

  always_comb begin
    case (w_size)
      SIZE_BYTE: w_wdata = {4{i_store_data[7:0]}};
      SIZE_HALF: w_wdata = {2{i_store_data[15:0]}};
      default:   w_wdata = i_store_data;
    endcase
  end

  load_extender #(.NB_REG(NB_REG)) u_load_extender (
    .i_rdata    (i_dmem_rdata),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_result   (w_load_ext)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_alu_pass   = 1'b0;
    w_reject     = 1'b0;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          if (!w_mem_op) begin
            w_alu_pass = 1'b1;
          end else if (w_misaligned) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_dmem_ack) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request side holds its values for the whole WAIT; MEM/WB defaults to a bubble.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= '0;
      r_addr       <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_wb_lat     <= '0;
      r_pc_lat     <= '0;
      r_reg_wb     <= '0;
      r_ext_mem    <= '0;
      r_wb         <= '0;
      r_pc         <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_wb         <= '0;
      r_misaligned <= w_reject;
      if (w_alu_pass) begin
        r_reg_wb  <= i_alu_result;
        r_ext_mem <= '0;
        r_wb      <= i_wb;
        r_pc      <= i_pc;
      end
      if (w_reject) begin
        r_wb <= w_wb_noreg;
      end
      if (w_accept) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= w_is_store;
        r_dmem_addr  <= {i_alu_result[NB_REG-1:2], 2'b00};
        r_dmem_wdata <= w_wdata;
        r_dmem_be    <= lane_be(w_size, i_alu_result[1:0]);
        r_addr       <= i_alu_result;
        r_size       <= w_size;
        r_uns        <= i_mem_ctrl[MC_UNS];
        r_wb_lat     <= i_wb;
        r_pc_lat     <= i_pc;
      end
      if (w_complete) begin
        r_dmem_req <= 1'b0;
        r_dmem_we  <= 1'b0;
        r_reg_wb   <= r_addr;
        r_ext_mem  <= r_dmem_we ? '0 : w_load_ext;
        r_wb       <= r_wb_lat;
        r_pc       <= r_pc_lat;
      end
    end
  end

  assign o_stall      = (r_state == ST_WAIT);
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_dmem_be    = r_dmem_be;
  assign o_reg_wb     = r_reg_wb;
  assign o_ext_mem_o  = r_ext_mem;
  assign o_wb         = r_wb;
  assign o_pc         = r_pc;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: each instruction pushes its expected
// MEM/WB result and output cycle; a monitor pops on every non-bubble output.
module tb_mem_access;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_mem_ctrl = '0;
  logic [7:0]  i_wb = '0;
  logic [31:0] i_pc = '0;
  logic        o_stall, o_dmem_req, o_dmem_we, o_misaligned;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_reg_wb, o_ext_mem_o, o_pc;
  logic [3:0]  o_dmem_be;
  logic [7:0]  o_wb;
  logic [31:0] i_dmem_rdata = '0;
  logic        i_dmem_ack = 1'b0;

  mem_access dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_mem_ctrl   (i_mem_ctrl),
    .i_wb         (i_wb),
    .i_pc         (i_pc),
    .o_stall      (o_stall),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_be    (o_dmem_be),
    .i_dmem_rdata (i_dmem_rdata),
    .i_dmem_ack   (i_dmem_ack),
    .o_reg_wb     (o_reg_wb),
    .o_ext_mem_o  (o_ext_mem_o),
    .o_wb         (o_wb),
    .o_pc         (o_pc),
    .o_misaligned (o_misaligned)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] reg_wb;
    logic [31:0] ext;
    logic [7:0]  wb;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_reg_wb = '0;
  logic [31:0] m_ext = '0;
  logic [31:0] m_pc = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    if (sz == 2'b00) return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return d;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (i_reset && (o_wb != 8'h00 || o_misaligned)) begin
        $display("txn cyc=%0d reg_wb=%08h ext=%08h wb=%02h pc=%08h mis=%0b",
                 cyc, o_reg_wb, o_ext_mem_o, o_wb, o_pc, o_misaligned);
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 32'({o_misaligned, o_wb}), 32'h0);
        end else begin
          e = sb.pop_front();
          check_eq("out_cycle", cyc, e.cyc);
          check_eq("out_reg_wb", o_reg_wb, e.reg_wb);
          check_eq("out_ext_mem", o_ext_mem_o, e.ext);
          check_eq("out_wb", 32'(o_wb), 32'(e.wb));
          check_eq("out_pc", o_pc, e.pc);
          check_eq("out_misaligned", 32'(o_misaligned), 32'(e.mis));
        end
      end
    end
  endtask

  // Called on a negedge in IDLE; returns on a negedge with i_valid low.
  task automatic do_op(input string name, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] ctrl, input logic [7:0] wb, input logic [31:0] pc,
                       input logic [31:0] rdata, input int ack_dly);
    exp_t        e;
    logic        mem_op, store, mis;
    logic [1:0]  sz, a;
    logic [3:0]  be;
    logic [31:0] wd, addr_al;
    int          stall_cnt;
    sz      = ctrl[1:0];
    a       = alu[1:0];
    store   = ctrl[3];
    mem_op  = ctrl[4] | ctrl[3];
    mis     = (sz == 2'b01 && a[0]) || (sz[1] && a != 2'b00);
    addr_al = alu & 32'hFFFF_FFFC;
    be      = (sz == 2'b00) ? (4'b0001 << a) : (sz == 2'b01) ? (4'b0011 << a) : 4'b1111;
    wd      = (sz == 2'b00) ? {4{sdata[7:0]}} : (sz == 2'b01) ? {2{sdata[15:0]}} : sdata;

    check_eq({name, "/stall_at_issue"}, 32'(o_stall), 32'h0);
    i_valid = 1'b1; i_alu_result = alu; i_store_data = sdata;
    i_mem_ctrl = ctrl; i_wb = wb; i_pc = pc; i_dmem_ack = 1'b0;

    e.mis = 1'b0;
    e.wb  = wb;
    if (!mem_op) begin
      m_reg_wb = alu; m_ext = '0; m_pc = pc;
      e.cyc = cyc + 1;
    end else if (mis) begin
      e.cyc = cyc + 1;
      e.wb  = wb & 8'hFB;
      e.mis = 1'b1;
    end else begin
      m_reg_wb = alu; m_pc = pc;
      m_ext = store ? 32'h0 : exp_load(rdata, a, sz, ctrl[2]);
      e.cyc = cyc + 2 + ack_dly;
    end
    e.reg_wb = m_reg_wb; e.ext = m_ext; e.pc = m_pc;
    sb.push_back(e);

    @(negedge i_clock);
    if (!mem_op || mis) begin
      check_eq({name, "/no_req"}, 32'(o_dmem_req), 32'h0);
      check_eq({name, "/no_stall"}, 32'(o_stall), 32'h0);
      i_valid = 1'b0;
    end else begin
      check_eq({name, "/req"}, 32'(o_dmem_req), 32'h1);
      check_eq({name, "/we"}, 32'(o_dmem_we), 32'(store));
      check_eq({name, "/addr"}, o_dmem_addr, addr_al);
      check_eq({name, "/be"}, 32'(o_dmem_be), 32'(be));
      if (store) check_eq({name, "/wdata"}, o_dmem_wdata, wd);
      // Upstream keeps presenting its next instruction; it must not be taken.
      i_mem_ctrl = 5'b00000; i_alu_result = 32'hDEAD_BEEF; i_wb = 8'hFF; i_pc = 32'hFFFF_FFF0;
      stall_cnt = 0;
      for (int k = 0; k <= ack_dly; k++) begin
        if (o_stall) stall_cnt++;
        check_eq({name, "/req_hold"}, 32'(o_dmem_req), 32'h1);
        check_eq({name, "/addr_hold"}, o_dmem_addr, addr_al);
        i_dmem_ack   = (k == ack_dly);
        i_dmem_rdata = (k == ack_dly) ? rdata : $urandom;
        @(negedge i_clock);
      end
      i_dmem_ack = 1'b0;
      i_valid    = 1'b0;
      check_eq({name, "/stall_cycles"}, stall_cnt, ack_dly + 1);
      check_eq({name, "/req_dropped"}, 32'(o_dmem_req), 32'h0);
      check_eq({name, "/stall_released"}, 32'(o_stall), 32'h0);
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge i_clock);
    check_eq("rst/stall", 32'(o_stall), 32'h0);
    check_eq("rst/req", 32'(o_dmem_req), 32'h0);
    check_eq("rst/be", 32'(o_dmem_be), 32'h0);
    check_eq("rst/wb", 32'(o_wb), 32'h0);
    check_eq("rst/reg_wb", o_reg_wb, 32'h0);
    i_reset = 1'b1;

    do_op("alu",     32'h0000_1234, 32'h0,         5'b00000, 8'h2E, 32'h100, 32'h0,         0);
    do_op("lb",      32'h0000_0103, 32'h0,         5'b10000, 8'h4D, 32'h104, 32'h80FF_FF7F, 2);
    do_op("sh",      32'h0000_0202, 32'h0000_ABCD, 5'b01001, 8'h41, 32'h108, 32'h0,         1);
    do_op("lw_mis",  32'h0000_0101, 32'h0,         5'b10010, 8'h5D, 32'h10C, 32'h0,         0);
    do_op("alu2",    32'hCAFE_0001, 32'h0,         5'b00000, 8'h16, 32'h110, 32'h0,         0);
    do_op("lw_a",    32'h0000_0300, 32'h0,         5'b10010, 8'h65, 32'h114, 32'h1122_3344, 0);
    do_op("lw_b",    32'h0000_0304, 32'h0,         5'b10010, 8'h6D, 32'h118, 32'hA5A5_0F0F, 0);
    do_op("lbu",     32'h0000_0102, 32'h0,         5'b10100, 8'h75, 32'h11C, 32'h1280_3456, 1);
    do_op("lh",      32'h0000_0002, 32'h0,         5'b10001, 8'h0D, 32'h120, 32'h9ABC_0000, 0);
    do_op("lhu",     32'h0000_0006, 32'h0,         5'b10101, 8'h15, 32'h124, 32'hF00D_1111, 3);
    do_op("sb",      32'h0000_0001, 32'h1234_5655, 5'b01000, 8'h19, 32'h128, 32'h0,         0);
    do_op("sw_rewe", 32'h0000_0008, 32'hDEAD_BEEF, 5'b11010, 8'h1D, 32'h12C, 32'h7777_7777, 1);
    do_op("sh_mis",  32'h0000_0003, 32'h0,         5'b01001, 8'h7C, 32'h130, 32'h0,         0);
    do_op("alu3",    32'h0000_0042, 32'h0,         5'b00000, 8'h0A, 32'h134, 32'h0,         0);

    // Ack while IDLE must not start or complete anything.
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge i_clock);
      check_eq("idle_ack/stall", 32'(o_stall), 32'h0);
      check_eq("idle_ack/req", 32'(o_dmem_req), 32'h0);
    end
    i_dmem_ack = 1'b0;

    // lhu in flight, then reset mid-WAIT and a stale ack after release.
    i_valid = 1'b1; i_alu_result = 32'h0; i_mem_ctrl = 5'b10101; i_wb = 8'h6E; i_pc = 32'h500;
    @(negedge i_clock);
    check_eq("rstwait/req_before", 32'(o_dmem_req), 32'h1);
    check_eq("rstwait/stall_before", 32'(o_stall), 32'h1);
    i_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    check_eq("rstwait/req", 32'(o_dmem_req), 32'h0);
    check_eq("rstwait/stall", 32'(o_stall), 32'h0);
    check_eq("rstwait/we", 32'(o_dmem_we), 32'h0);
    check_eq("rstwait/be", 32'(o_dmem_be), 32'h0);
    check_eq("rstwait/addr", o_dmem_addr, 32'h0);
    check_eq("rstwait/wdata", o_dmem_wdata, 32'h0);
    check_eq("rstwait/reg_wb", o_reg_wb, 32'h0);
    check_eq("rstwait/ext", o_ext_mem_o, 32'h0);
    check_eq("rstwait/wb", 32'(o_wb), 32'h0);
    check_eq("rstwait/pc", o_pc, 32'h0);
    check_eq("rstwait/mis", 32'(o_misaligned), 32'h0);
    m_reg_wb = '0; m_ext = '0; m_pc = '0;
    @(negedge i_clock);
    i_reset = 1'b1; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1234_5678;
    repeat (2) @(negedge i_clock);
    i_dmem_ack = 1'b0;
    check_eq("late_ack/stall", 32'(o_stall), 32'h0);
    check_eq("late_ack/req", 32'(o_dmem_req), 32'h0);
    check_eq("late_ack/ext", o_ext_mem_o, 32'h0);

    do_op("alu_post", 32'h0000_0777, 32'h0, 5'b00000, 8'h22, 32'h600, 32'h0, 0);

    repeat (3) @(negedge i_clock);
    check_eq("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameters NB_REG 32 (data/address width), NB_REG_ADDR 5 (register index width), NB_WB 8 (write-back control width), NB_MEM_CTRL 5 (memory control width).
REQ-002 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 i_alu_result  in  NB_REG  address for loads/stores; result for ALU instructions.
REQ-006 i_store_data  in  NB_REG  store operand, right-aligned.
REQ-007 i_mem_ctrl  in  NB_MEM_CTRL  {re, we, unsigned, size[1:0]}; size is 00 byte, 01 half, 10 word.
REQ-008 i_wb  in  NB_WB  {reg_dest[4:0], reg_we, data_sel[1:0]}; passes through to write-back.
REQ-009 i_pc  in  NB_REG  return address, passed through.
REQ-010 o_stall  out  1  upstream SHALL hold its outputs while high.
REQ-011 o_dmem_req, o_dmem_we  out  1 each  data memory request and write strobe, registered.
REQ-012 o_dmem_addr  out  NB_REG  word-aligned address ({addr[31:2],2'b00}), registered.
REQ-013 o_dmem_wdata, o_dmem_be  out  NB_REG, 4  lane-shifted store data and byte enables, registered.
REQ-014 i_dmem_rdata, i_dmem_ack  in  NB_REG, 1  read data, valid when ack is high; ack completes the request.
REQ-015 o_reg_wb, o_ext_mem_o, o_wb, o_pc  out  NB_REG, NB_REG, NB_WB, NB_REG  MEM/WB pipeline register.
REQ-016 o_misaligned  out  1  one-cycle pulse on a rejected misaligned access.

Function
REQ-017 FSM states: IDLE and WAIT; o_stall = (state == WAIT).
REQ-018 IDLE, i_valid, re|we = 0: MEM/WB SHALL load {i_alu_result, 0, i_wb, i_pc} at the next edge (1-cycle latency).
REQ-019 IDLE, i_valid, memory op, aligned: latch addr/ctrl/wb/pc; assert req (with we = i_mem_ctrl.we); go to WAIT; MEM/WB loads a bubble.
REQ-020 WAIT: req/addr/we/wdata/be SHALL stay stable until the ack edge; no ack means the state stays WAIT and a bubble is loaded.
REQ-021 WAIT with i_dmem_ack: MEM/WB loads {latched addr, extended rdata (0 for stores), latched wb, latched pc}; req drops; next state is IDLE.
REQ-022 Bubble: o_wb = 0 (reg_we = 0, data_sel = 00); o_reg_wb, o_ext_mem_o and o_pc are held.
REQ-023 IDLE with i_valid low SHALL load a bubble.
REQ-024 Load extension: the byte or half is selected by addr[1:0] (little-endian), then sign-extended, or zero-extended when unsigned; a word passes unchanged.
REQ-025 Store lanes: byte be = 0001<<addr[1:0]; half be = 0011<<addr[1:0]; word be = 1111; wdata is replicated across lanes.
REQ-026 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; no request is made, o_misaligned pulses for one cycle, and MEM/WB loads i_wb with reg_we forced to 0.
REQ-027 re and we both set SHALL be treated as a store.
REQ-028 An ack while IDLE SHALL be ignored.
REQ-029 At most one request is outstanding.

Reset
REQ-030 Async assertion: state = IDLE; o_dmem_req, o_dmem_we, o_misaligned, o_stall = 0; o_dmem_be = 0; all data/address/MEM/WB outputs = 0.
REQ-031 Reset during WAIT SHALL abandon the request immediately; a later ack SHALL be ignored.
REQ-032 Deassertion is taken synchronously by the integrating design; the first edge after release behaves as IDLE.

Structure
REQ-033 A shared package SHALL hold the mem_ctrl field indices, the size encodings, the WB field layout {reg_dest, reg_we, data_sel}, and the FSM state encodings.
REQ-034 The block SHALL contain one combinational sub-module, load_extender (rdata, addr[1:0], size, unsigned -> NB_REG result).

Verification
REQ-035 ALU op, alu_result=0x0000_1234, i_wb=0x2E -> next cycle o_reg_wb=0x1234, o_wb=0x2E, o_stall never high.
REQ-036 lb signed at addr 0x103, ack 2 cycles after req, rdata=0x80FF_FF7F -> o_ext_mem_o=0xFFFF_FF80; o_stall high for 3 cycles; bubbles meanwhile.
REQ-037 sh at addr 0x202, data 0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, addr=0x200; o_wb reg_we=0.
REQ-038 lw at addr 0x101 -> o_misaligned pulse, o_dmem_req never high, o_wb reg_we=0, next instruction accepted the following cycle.
REQ-039 lhu at addr 0x0, reset asserted in WAIT, ack arriving after release -> outputs zero, state IDLE, ack ignored.
REQ-040 Back-to-back lw/lw with same-cycle acks -> each completes in 2 cycles, upstream held exactly 1 cycle per load.
